demux16_4: RTL and testbench
============================

# demux16_4

Registered 1-to-4 demultiplexer that steers 16-bit words from one valid/ready input stream to one of four output channels selected per word. Each channel owns a single-entry holding register, so a stalled channel does not block words bound for other channels once its slot is drained. It is the distribution end of the 16-bit select datapath, feeding separate consumers (register-file write ports, ALU operand latches) from one shared source.

## Interface
- `WIDTH`, 16, data word width in bits.
- `clk` input 1, rising-edge clock.
- `rst_n` input 1, asynchronous active-low reset.
- `clr` input 1, synchronous clear; empties all four slots.
- `in_data` input WIDTH, word to route.
- `in_sel` input 2, destination channel index 0..3.
- `in_valid` input 1, `in_data`/`in_sel` valid.
- `in_ready` output 1, block accepts the word this cycle.
- `out_data` output 4*WIDTH, channel k at bits [k*WIDTH +: WIDTH].
- `out_valid` output 4, slot k holds a word.
- `out_ready` input 4, consumer k takes the word this cycle.
- `cnt` output 32, per-channel accepted-word counters, channel k at bits [k*8 +: 8].

## Operation
- Accept: `acc = in_valid & in_ready`; the word is written into slot `in_sel`, and `out_valid[in_sel]` is 1 on the next cycle.
- `in_ready = ~clr & (~out_valid[in_sel] | out_ready[in_sel])`.
  - Ready depends only on the addressed slot; other slots are ignored.
  - A full slot being drained in the same cycle accepts a new word, giving back-to-back throughput of one word per cycle per channel.
- Drain: `out_valid[k] & out_ready[k]` empties slot k unless it is refilled by `acc` in the same cycle. In that case slot k stays valid with the new data.
- Slot data holds its value while valid and not drained. Data in empty slots is don't-care; the implementation holds the last value.
- Per slot, the state is EMPTY or FULL:
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY on drain without refill.
  - FULL -> FULL on drain with refill, or while held.
  - Any state -> EMPTY on `clr`.
- `clr` empties all slots in one cycle, forces `in_ready` = 0, and discards any offered input. `clr` wins over simultaneous accept and drain.
- Word order is preserved per channel. There is no ordering between channels.

## Timing
- Latency from input accept to `out_valid` is 1 cycle.
- There is a combinational path from `out_ready` and `in_sel` to `in_ready`. No path goes from `in_valid` to `in_ready`.
- Reset values:
  - `out_valid` = 4'b0000, `out_data` = 0, `cnt` = 0.
  - `in_ready` = 1 while `clr` = 0, because all slots are empty.
- Reset mid-transfer drops all held words immediately (asynchronous). The first accept is possible on the first clock edge after `rst_n` rises.
- Outputs change only on `clk` rising edge or `rst_n` assertion. `in_ready` is the only combinational output.
- Producer rule: hold `in_data`/`in_sel` stable while `in_valid` = 1 and `in_ready` = 0.

## Configuration
- `DEMUX_CNT_EN` defined:
  - Each channel has an 8-bit counter that increments by 1 on every accept to that channel.
  - The counter wraps 255 -> 0.
  - Counters clear on `rst_n` and on `clr`.
- `DEMUX_CNT_EN` undefined: `cnt` is tied to 0 and no counter flops exist. The port list is unchanged.

## Structure
- Shared package `demux_pkg` holds:
  - `CH_NUM` = 4, `SEL_W` = 2, `CNT_W` = 8.
  - The `slot_state_e` enum: EMPTY, FULL.
- Sub-module `demux_slot`: a one-entry holding register.
  - Inputs: `wr`, `wdata`, `rd`, `clr`.
  - Outputs: `valid`, `data`.
  - Optional counter under `DEMUX_CNT_EN`.
- `demux16_4` instantiates four `demux_slot`s and contains the select decode and `in_ready` logic.

## Test plan
- Reset and basic routing: reset, `out_ready` = 4'b1111, send 0x1111 sel 0, 0x2222 sel 1, 0x3333 sel 2, 0x4444 sel 3 on consecutive cycles. Each appears on its channel exactly one cycle after accept, and `out_valid` is one-hot each cycle.
- Backpressure isolation: `out_ready[2]` = 0, send 0xAAAA sel 2, then 0xBBBB sel 2, then 0xCCCC sel 0.
  - `in_ready` = 0 while 0xBBBB is offered.
  - 0xCCCC is not accepted while 0xBBBB blocks the input (it is queued behind it).
  - Release `out_ready[2]`: 0xBBBB is accepted the same cycle 0xAAAA drains, then 0xCCCC follows.
- Full-rate single channel: `out_ready[1]` = 1, 8 consecutive words 0x0001..0x0008 to sel 1. The words are accepted every cycle and appear in order with no bubbles.
- Clear: fill all four slots, assert `clr` for 1 cycle with `in_valid` = 1.
  - `out_valid` = 0 next cycle and `in_ready` = 0 during `clr`.
  - The offered word is not delivered.
- Async reset mid-stream: drop `rst_n` between clock edges while slots are full. `out_valid` goes to 0 immediately, without a clock edge.
- Counter (`DEMUX_CNT_EN`): 257 accepts to sel 3, then `cnt[31:24]` = 1 and the other counters = 0. Without the macro, `cnt` = 0 throughout.

Source files
------------

// File: rtl/demux_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : demux_pkg
//  Description : Shared constants and slot state encoding for demux16_4.
//  Revision    : 1.0  initial release
// ============================================================================
package demux_pkg;

    localparam int CH_NUM = 4;
    localparam int SEL_W  = 2;
    localparam int CNT_W  = 8;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_e;

endpackage : demux_pkg
`default_nettype wire

// File: rtl/demux_slot.sv
`default_nettype none
// ============================================================================
//  Module      : demux_slot
//  Description : Single-entry holding register for one demux output channel,
//                with an optional accepted-word counter (DEMUX_CNT_EN).
//  Revision    : 1.0  initial release
// ============================================================================
module demux_slot
    import demux_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              wr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              rd,
    output logic              valid,
    output logic [WIDTH-1:0]  data,
    output logic [CNT_W-1:0]  cnt
);

    slot_state_e      r_state;
    slot_state_e      w_state_nxt;
    logic [WIDTH-1:0] r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // clr overrides both refill and drain
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            EMPTY:   if (wr)        w_state_nxt = FULL;
            FULL:    if (rd && !wr) w_state_nxt = EMPTY;
            default:                w_state_nxt = EMPTY;
        endcase
        if (clr) begin
            w_state_nxt = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
        end else if (wr && !clr) begin
            r_data <= wdata;
        end
    end

    assign valid = (r_state == FULL);
    assign data  = r_data;

`ifdef DEMUX_CNT_EN
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (wr) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign cnt = r_cnt;
`else
    assign cnt = '0;
`endif

endmodule : demux_slot
`default_nettype wire

// File: rtl/demux16_4.sv
`default_nettype none
// ============================================================================
//  Module      : demux16_4
//  Description : Registered 1-to-4 valid/ready demultiplexer with one holding
//                slot per channel. Optional per-channel counters: DEMUX_CNT_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module demux16_4
    import demux_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic [WIDTH-1:0]        in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [CH_NUM*WIDTH-1:0] out_data,
    output logic [CH_NUM-1:0]       out_valid,
    input  logic [CH_NUM-1:0]       out_ready,
    output logic [CH_NUM*CNT_W-1:0] cnt
);

    logic [CH_NUM-1:0] w_valid;
    logic [CH_NUM-1:0] w_wr;
    logic              w_acc;

    // Only the addressed slot gates acceptance; in_valid never feeds in_ready
    assign in_ready = ~clr & (~w_valid[in_sel] | out_ready[in_sel]);
    assign w_acc    = in_valid & in_ready;

    genvar k;
    generate
        for (k = 0; k < CH_NUM; k++) begin : g_slot
            assign w_wr[k] = w_acc & (in_sel == SEL_W'(k));

            demux_slot #(
                .WIDTH (WIDTH)
            ) u_slot (
                .clk   (clk),
                .rst_n (rst_n),
                .clr   (clr),
                .wr    (w_wr[k]),
                .wdata (in_data),
                .rd    (out_ready[k]),
                .valid (w_valid[k]),
                .data  (out_data[k*WIDTH +: WIDTH]),
                .cnt   (cnt[k*CNT_W +: CNT_W])
            );
        end
    endgenerate

    assign out_valid = w_valid;

endmodule : demux16_4
`default_nettype wire

// File: tb/tb_demux16_4.sv
`default_nettype none
// ============================================================================
//  Module      : tb_demux16_4
//  Description : Directed self-checking bench for demux16_4.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_demux16_4;

    logic        clk;
    logic        rst_n;
    logic        clr;
    logic [15:0] in_data;
    logic [1:0]  in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] out_data;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [31:0] cnt;

    int checks   = 0;
    int failures = 0;

`ifdef DEMUX_CNT_EN
    localparam logic [31:0] c_cnt_257 = 32'h0100_0000;
`else
    localparam logic [31:0] c_cnt_257 = 32'h0000_0000;
`endif

    demux16_4 #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .cnt       (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] ch(input int k);
        return out_data[k*16 +: 16];
    endfunction

    logic [15:0] r1_vec [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    int          w_stall;

    initial begin
        rst_n = 1'b0; clr = 1'b0; in_data = '0; in_sel = '0; in_valid = 1'b0; out_ready = 4'h0;
        repeat (2) tick();
        check_eq("rst_out_valid", 64'(out_valid), 64'h0);
        check_eq("rst_out_data", out_data, 64'h0);
        check_eq("rst_cnt", 64'(cnt), 64'h0);
        check_eq("rst_in_ready", 64'(in_ready), 64'h1);
        rst_n = 1'b1;
        tick();

        // basic routing, one-hot delivery
        out_ready = 4'hF;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = r1_vec[i]; in_sel = 2'(i);
            #1 check_eq("route_in_ready", 64'(in_ready), 64'h1);
            tick();
            check_eq("route_valid", 64'(out_valid), 64'(4'b0001 << i));
            check_eq("route_data", 64'(ch(i)), 64'(r1_vec[i]));
        end
        in_valid = 1'b0;
        tick();
        check_eq("route_idle", 64'(out_valid), 64'h0);

        // backpressure on channel 2
        out_ready = 4'b1011;
        in_valid = 1'b1; in_data = 16'hAAAA; in_sel = 2'd2;
        #1 check_eq("bp_accept_a", 64'(in_ready), 64'h1);
        tick();
        in_data = 16'hBBBB;
        #1 check_eq("bp_block_b", 64'(in_ready), 64'h0);
        tick();
        check_eq("bp_hold_valid", 64'(out_valid), 64'h4);
        check_eq("bp_hold_data", 64'(ch(2)), 64'hAAAA);
        check_eq("bp_still_block", 64'(in_ready), 64'h0);
        tick();
        check_eq("bp_hold_data2", 64'(ch(2)), 64'hAAAA);
        out_ready = 4'hF;
        #1 check_eq("bp_release", 64'(in_ready), 64'h1);
        tick();
        check_eq("bp_b_valid", 64'(out_valid), 64'h4);
        check_eq("bp_b_data", 64'(ch(2)), 64'hBBBB);
        in_data = 16'hCCCC; in_sel = 2'd0;
        #1 check_eq("bp_c_ready", 64'(in_ready), 64'h1);
        tick();
        check_eq("bp_c_valid", 64'(out_valid), 64'h1);
        check_eq("bp_c_data", 64'(ch(0)), 64'hCCCC);
        in_valid = 1'b0;
        tick();

        // full rate on channel 1
        out_ready = 4'b0010;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_data = 16'(i); in_sel = 2'd1;
            #1 check_eq("rate_ready", 64'(in_ready), 64'h1);
            tick();
            check_eq("rate_valid", 64'(out_valid), 64'h2);
            check_eq("rate_data", 64'(ch(1)), 64'(i));
        end
        in_valid = 1'b0;
        tick();
        check_eq("rate_drained", 64'(out_valid), 64'h0);

        // clear with a word offered
        out_ready = 4'h0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = 16'(16'h5000 + i); in_sel = 2'(i);
            tick();
        end
        check_eq("clr_filled", 64'(out_valid), 64'hF);
        clr = 1'b1; in_valid = 1'b1; in_sel = 2'd0; in_data = 16'hDEAD;
        #1 check_eq("clr_in_ready", 64'(in_ready), 64'h0);
        tick();
        clr = 1'b0; in_valid = 1'b0;
        check_eq("clr_valid", 64'(out_valid), 64'h0);
        check_eq("clr_cnt", 64'(cnt), 64'h0);
        tick();
        check_eq("clr_no_deliver", 64'(out_valid), 64'h0);

        // asynchronous reset mid-stream
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = 16'(16'h6000 + i); in_sel = 2'(i);
            tick();
        end
        in_valid = 1'b0;
        check_eq("arst_filled", 64'(out_valid), 64'hF);
        #2 rst_n = 1'b0;
        #1 check_eq("arst_valid", 64'(out_valid), 64'h0);
        check_eq("arst_data", out_data, 64'h0);
        check_eq("arst_cnt", 64'(cnt), 64'h0);
        rst_n = 1'b1;
        in_valid = 1'b1; in_data = 16'h7777; in_sel = 2'd3; out_ready = 4'hF;
        tick();
        check_eq("arst_first_valid", 64'(out_valid), 64'h8);
        check_eq("arst_first_data", 64'(ch(3)), 64'h7777);

        // counter: clear, then 257 accepts to channel 3
        clr = 1'b1; in_valid = 1'b0;
        tick();
        clr = 1'b0;
        w_stall = 0;
        for (int i = 0; i < 257; i++) begin
            in_valid = 1'b1; in_data = 16'(i); in_sel = 2'd3;
            #1 if (!in_ready) w_stall++;
            tick();
        end
        in_valid = 1'b0;
        tick();
        check_eq("cnt_no_stall", 64'(w_stall), 64'h0);
        check_eq("cnt_257", 64'(cnt), 64'(c_cnt_257));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_demux16_4
`default_nettype wire
